exec_control: RTL and testbench
===============================

# exec_control

Run/step execution controller for the 16-bit RISC processor. It consumes the one-shot pulses from the button debouncers (step, run/stop, clear) and turns them into a paced, handshaked single-instruction enable for the CPU datapath. It also keeps a retired-instruction count for the display path. It sits between the debounce stage and the CPU control unit.

## Interface
- RUN_DIV, 4: idle cycles inserted between consecutive instructions in run mode; legal range 1..65535.
- CNT_W, 16: width of the retired-instruction counter.

- clk_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- step_p  input  1  one-cycle pulse from a debouncer: execute one instruction.
- run_p  input  1  one-cycle pulse from a debouncer: start run mode, or stop it if already running.
- clr_p  input  1  one-cycle pulse from a debouncer: leave HALTED and clear the counter.
- halt_req  input  1  level from the CPU: a HALT instruction has been decoded.
- cpu_done  input  1  one-cycle pulse from the CPU: the issued instruction has retired.
- cpu_en  output  1  one-cycle enable to the CPU: start one instruction.
- running  output  1  high while run mode is active.
- halted  output  1  high in HALTED.
- instr_cnt  output  CNT_W  retired-instruction count.

## Operation
- FSM states: IDLE, ISSUE, WAIT, GAP, HALTED. An internal run_mode flag and stop_pend flag accompany the state.
- IDLE:
  - run_p → ISSUE, and run_mode is set.
  - step_p → ISSUE, and run_mode is cleared.
  - If run_p and step_p arrive in the same cycle, run_p wins.
- ISSUE: cpu_en = 1 for exactly one cycle, then WAIT unconditionally.
- WAIT: hold until cpu_done. On cpu_done, instr_cnt increments. The counter wraps from all-ones to 0 with no flag. The next state is the first true of:
  1. halt_req = 1 → HALTED. run_mode and stop_pend are cleared.
  2. run_mode = 0, or stop_pend = 1 → IDLE. run_mode and stop_pend are cleared.
  3. Otherwise → GAP, with the pace counter loaded to RUN_DIV − 1.
- run_p during ISSUE or WAIT while run_mode = 1 sets stop_pend. The in-flight instruction always completes; it is never aborted.
- GAP:
  - The pace counter decrements each cycle. When it reads 0 → ISSUE.
  - run_p → IDLE immediately; run_mode is cleared.
  - halt_req → HALTED. The halt check has priority over run_p.
- HALTED: step_p and run_p are ignored. clr_p → IDLE and clears instr_cnt to 0.
- clr_p in any state other than HALTED clears only instr_cnt. If clr_p coincides with a cpu_done increment, the clear wins.
- step_p outside IDLE is ignored. No pulses are queued.
- cpu_done outside WAIT is ignored. The counter does not change.
- halt_req is sampled only in WAIT (on cpu_done) and in GAP.

## Timing
- Reset (reset = 0):
  - Asynchronously forces state IDLE, run_mode = 0, stop_pend = 0, pace counter = 0.
  - Outputs: cpu_en = 0, running = 0, halted = 0, instr_cnt = 0.
- Reset asserted mid-instruction abandons the handshake. A later cpu_done is ignored because the state is IDLE.
- All outputs are registered or derived only from state, with no combinational input-to-output path:
  - cpu_en = (state == ISSUE).
  - halted = (state == HALTED).
  - running = run_mode.
- Latencies:
  - step_p or run_p sampled high in IDLE at edge t → cpu_en high during cycle t+1.
  - cpu_done sampled at edge t → instr_cnt updated in cycle t+1.
- Run-mode period, with cpu_done arriving k cycles after cpu_en (k ≥ 1): 1 + k + RUN_DIV cycles per instruction.

## Structure
- Shared package exec_control_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, GAP, HALTED);
  - the RUN_DIV and CNT_W default constants.
- One natural sub-module, pace_counter: a loadable down-counter with load, load value and zero flag, sized by $clog2(RUN_DIV)+1.
- FSM, flags and instr_cnt live in exec_control.

## Test plan
- Reset then single step: reset low 3 cycles then high; step_p at cycle 5; CPU model returns cpu_done 2 cycles after cpu_en → cpu_en high only in cycle 6; instr_cnt = 1; state IDLE; running = 0.
- Run pacing: RUN_DIV = 4, done latency 1; run_p once → cpu_en pulses every 6 cycles; after 10 pulses, instr_cnt = 10.
- Stop during WAIT: run_p in WAIT of the 3rd instruction → that instruction retires; instr_cnt = 3; no further cpu_en; running = 0.
- Halt and clear: halt_req = 1 with the 5th cpu_done → halted = 1 and instr_cnt = 5; step_p and run_p produce no cpu_en; clr_p → IDLE with instr_cnt = 0.
- Wrap and collisions:
  - Preload instr_cnt = 0xFFFF, one step → instr_cnt = 0x0000.
  - run_p and step_p in the same IDLE cycle → running = 1.
  - clr_p coincident with cpu_done → instr_cnt = 0.
- Async reset mid-WAIT: reset low for 1 cycle, then a stray cpu_done → no count change; all outputs 0.

Source files
------------

// File: rtl/exec_control_pkg.sv
// exec_control_pkg: shared state encoding and default sizing for the run/step execution controller.
package exec_control_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, HALTED} state_t;
    localparam int RUN_DIV_DEF = 4;
    localparam int CNT_W_DEF   = 16;
endpackage

// File: rtl/exec_control_pace_counter.sv
// pace_counter: loadable down-counter that paces run-mode issue; holds at zero.
module pace_counter #(
    parameter int W = 3
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/exec_control.sv
// exec_control: turns debounced step/run/clear pulses into a paced, handshaked
// single-instruction enable for the CPU and counts retired instructions.
module exec_control
    import exec_control_pkg::*;
#(
    parameter int RUN_DIV = RUN_DIV_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             step_p,
    input  logic             run_p,
    input  logic             clr_p,
    input  logic             halt_req,
    input  logic             cpu_done,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam int PW = $clog2(RUN_DIV) + 1;
    localparam logic [PW-1:0] PACE_LOAD = PW'(RUN_DIV - 1);
    state_t r_state, w_next;
    logic r_run_mode, r_stop_pend, w_run_mode, w_stop_pend, w_load, w_zero;
    logic [CNT_W-1:0] r_cnt;
    pace_counter #(.W(PW)) u_pace (
        .clk_in (clk_in),
        .reset  (reset),
        .i_load (w_load),
        .i_val  (PACE_LOAD),
        .i_dec  (r_state == GAP),
        .o_zero (w_zero)
    );
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_run_mode  <= 1'b0;
            r_stop_pend <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next;
            r_run_mode  <= w_run_mode;
            r_stop_pend <= w_stop_pend;
            if (clr_p) r_cnt <= '0;
            else if (r_state == WAIT && cpu_done) r_cnt <= r_cnt + 1'b1;
        end
    end
    // A stop request seen on the retire cycle itself still ends run mode.
    always_comb begin
        w_next      = r_state;
        w_run_mode  = r_run_mode;
        w_stop_pend = r_stop_pend;
        w_load      = 1'b0;
        if ((r_state == ISSUE || r_state == WAIT) && run_p && r_run_mode) w_stop_pend = 1'b1;
        case (r_state)
            IDLE: begin
                if (run_p || step_p) begin
                    w_next     = ISSUE;
                    w_run_mode = run_p;
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (cpu_done) begin
                    if (halt_req || !r_run_mode || w_stop_pend) begin
                        w_next      = halt_req ? HALTED : IDLE;
                        w_run_mode  = 1'b0;
                        w_stop_pend = 1'b0;
                    end else begin
                        w_next = GAP;
                        w_load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (halt_req || run_p) begin
                    w_next      = halt_req ? HALTED : IDLE;
                    w_run_mode  = 1'b0;
                    w_stop_pend = 1'b0;
                end else if (w_zero) begin
                    w_next = ISSUE;
                end
            end
            HALTED: w_next = clr_p ? IDLE : HALTED;
            default: w_next = IDLE;
        endcase
    end
    assign cpu_en    = (r_state == ISSUE);
    assign halted    = (r_state == HALTED);
    assign running   = r_run_mode;
    assign instr_cnt = r_cnt;
endmodule

// File: tb/tb_exec_control.sv
// tb_exec_control: directed scenarios with a cpu_en cycle scoreboard and a simple CPU model.
module tb_exec_control;
    logic clk_in = 1'b0, reset = 1'b0;
    logic step_p = 0, run_p = 0, clr_p = 0, halt_req = 0, cpu_done = 0;
    logic cpu_en, running, halted;
    logic [15:0] instr_cnt;
    logic step_w = 0, done_w = 0, cpu_en_w, running_w, halted_w;
    logic [3:0] cnt_w;
    int total = 0, bad = 0, cyc = 0;
    int lat = 1, pend = 0, ndone = 0, halt_on = 0;
    bit auto_done = 1;
    int exp_q[$];
    int m;

    always #5 clk_in = ~clk_in;

    exec_control dut (
        .clk_in(clk_in), .reset(reset), .step_p(step_p), .run_p(run_p), .clr_p(clr_p),
        .halt_req(halt_req), .cpu_done(cpu_done), .cpu_en(cpu_en), .running(running),
        .halted(halted), .instr_cnt(instr_cnt)
    );

    // Narrow counter instance so the wrap from all-ones is reachable quickly.
    exec_control #(.RUN_DIV(1), .CNT_W(4)) dut_w (
        .clk_in(clk_in), .reset(reset), .step_p(step_w), .run_p(1'b0), .clr_p(1'b0),
        .halt_req(1'b0), .cpu_done(done_w), .cpu_en(cpu_en_w), .running(running_w),
        .halted(halted_w), .instr_cnt(cnt_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        int e;
        @(posedge clk_in);
        #1;
        cyc++;
        step_p = 0; run_p = 0; clr_p = 0; cpu_done = 0; step_w = 0; done_w = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                cpu_done = 1;
                ndone++;
                if (ndone == halt_on) halt_req = 1;
            end
        end
        if (cpu_en) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            chk("cpu_en_cycle", cyc, e);
            if (auto_done) pend = lat;
        end
    endtask

    initial begin
        // Reset then single step
        repeat (3) tick();
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", instr_cnt, 0);
        reset = 1;
        repeat (2) tick();
        lat = 2;
        step_p = 1; exp_q.push_back(cyc + 1);
        repeat (4) tick();
        chk("step_cnt", instr_cnt, 1);
        chk("step_running", running, 0);
        chk("step_idle_en", cpu_en, 0);
        chk("step_sb_empty", exp_q.size(), 0);

        // Run pacing: period 1 + 1 + 4
        lat = 1;
        clr_p = 1; tick();
        chk("clr_idle_cnt", instr_cnt, 0);
        m = cyc;
        run_p = 1;
        for (int i = 0; i < 10; i++) exp_q.push_back(m + 1 + 6 * i);
        repeat (57) tick();
        chk("run_cnt10", instr_cnt, 10);
        chk("run_running", running, 1);
        run_p = 1;
        repeat (8) tick();
        chk("gap_stop_running", running, 0);
        chk("run_sb_empty", exp_q.size(), 0);

        // Stop during WAIT of the 3rd instruction; step in WAIT is ignored
        lat = 3;
        clr_p = 1; tick();
        m = cyc;
        run_p = 1;
        for (int i = 0; i < 3; i++) exp_q.push_back(m + 1 + 8 * i);
        repeat (2) tick();
        step_p = 1;
        repeat (16) tick();
        chk("stop_pre_running", running, 1);
        run_p = 1;
        repeat (10) tick();
        chk("stop_cnt", instr_cnt, 3);
        chk("stop_running", running, 0);
        chk("stop_sb_empty", exp_q.size(), 0);

        // run_p + step_p together, then clr_p coincident with cpu_done
        lat = 1;
        run_p = 1; step_p = 1; exp_q.push_back(cyc + 1);
        tick();
        chk("both_running", running, 1);
        run_p = 1;
        tick();
        chk("coll_done_seen", cpu_done, 1);
        clr_p = 1;
        tick();
        chk("coll_cnt", instr_cnt, 0);
        chk("coll_running", running, 0);
        repeat (8) tick();
        chk("coll_sb_empty", exp_q.size(), 0);

        // Halt with the 5th retire, ignored pulses, clear
        ndone = 0; halt_on = 5;
        m = cyc;
        run_p = 1;
        for (int i = 0; i < 5; i++) exp_q.push_back(m + 1 + 6 * i);
        repeat (27) tick();
        chk("halt_halted", halted, 1);
        chk("halt_cnt", instr_cnt, 5);
        chk("halt_running", running, 0);
        step_p = 1; tick();
        run_p = 1; tick();
        repeat (4) tick();
        chk("halt_hold", halted, 1);
        chk("halt_sb_empty", exp_q.size(), 0);
        halt_req = 0; halt_on = 0;
        clr_p = 1; tick();
        chk("clr_halted", halted, 0);
        chk("clr_cnt", instr_cnt, 0);
        chk("clr_cpu_en", cpu_en, 0);

        // Counter wrap on the narrow instance
        for (int i = 0; i < 16; i++) begin
            step_w = 1; tick();
            tick();
            done_w = 1; tick();
            if (i == 14) chk("wrap_allones", cnt_w, 4'hF);
        end
        chk("wrap_zero", cnt_w, 0);
        chk("wrap_running", running_w, 0);

        // Async reset mid-WAIT, then a stray cpu_done
        step_p = 1; exp_q.push_back(cyc + 1);
        repeat (3) tick();
        chk("pre_rst_cnt", instr_cnt, 1);
        auto_done = 0;
        step_p = 1; exp_q.push_back(cyc + 1);
        repeat (2) tick();
        reset = 0;
        #1;
        chk("async_cnt", instr_cnt, 0);
        chk("async_cpu_en", cpu_en, 0);
        tick();
        reset = 1;
        cpu_done = 1;
        repeat (3) tick();
        chk("stray_cnt", instr_cnt, 0);
        chk("stray_cpu_en", cpu_en, 0);
        chk("stray_running", running, 0);
        chk("stray_halted", halted, 0);
        chk("end_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
